camera_pattern_gen: RTL and testbench
=====================================

CAMERA_PATTERN_GEN -- requirements
Module: camera_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 16: LVAL-low cycles between lines.
REQ-004 SHALL have parameter FV_LEAD, default 4: FVAL-high, LVAL-low cycles before the first line.
REQ-005 SHALL have parameter FV_TRAIL, default 4: FVAL-high, LVAL-low cycles after the last line.
REQ-006 SHALL have parameter V_BLANK, default 64: FVAL-low cycles between frames.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; one pixel per cycle.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: run request, sampled only at frame boundaries.
REQ-010 SHALL have port pattern_sel, input, 2 bits: test pattern code.
REQ-011 SHALL have port fval, output, 1 bit: frame valid, matching the camera receiver conduit FVAL.
REQ-012 SHALL have port lval, output, 1 bit: line valid, matching the camera receiver conduit LVAL.
REQ-013 SHALL have port d, output, 12 bits: pixel data, matching the camera receiver conduit D.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 SHALL have port frame_count, output, 16 bits: count of completed frames.

Function
REQ-016 SHALL implement FSM states IDLE, LEAD, LINE, HBLK, TRAIL, VBLK.
REQ-017 IDLE SHALL go to LEAD on the clock edge where enable=1; otherwise IDLE SHALL hold.
REQ-018 LEAD SHALL last FV_LEAD cycles, then go to LINE with x=0 and y=0.
REQ-019 LINE SHALL last H_ACTIVE cycles, with x incrementing 0..H_ACTIVE-1.
REQ-020 At the end of LINE, if y<V_ACTIVE-1, the FSM SHALL go to HBLK; otherwise it SHALL go directly to TRAIL, with no HBLK after the last line.
REQ-021 HBLK SHALL last H_BLANK cycles, then increment y, clear x and return to LINE.
REQ-022 TRAIL SHALL last FV_TRAIL cycles, then go to VBLK.
REQ-023 VBLK SHALL last V_BLANK cycles; at its end, enable=1 SHALL go to LEAD and enable=0 SHALL go to IDLE.
REQ-024 fval SHALL be 1 in LEAD, LINE, HBLK and TRAIL, and 0 elsewhere.
REQ-025 lval SHALL be 1 only in LINE.
REQ-026 All outputs SHALL be registered, one cycle after the state decode, so fval, lval and d are mutually aligned.
REQ-027 d SHALL be 12'h000 whenever lval=0.
REQ-028 Pattern 0 SHALL drive d = x[11:0] (horizontal ramp; wraps modulo 4096).
REQ-029 Pattern 1 SHALL drive d = y[11:0] (vertical ramp).
REQ-030 Pattern 2 SHALL drive d = 12'hFFF when x[3]^y[3]=1, else 12'h000 (8x8 checkerboard).
REQ-031 Pattern 3 SHALL drive d = {x[1:0], y[1:0], 8'h00} (Bayer-phase marker).
REQ-032 pattern_sel SHALL be latched on entry to LEAD; a change mid-frame SHALL NOT affect the current frame.
REQ-033 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame SHALL complete through VBLK, then go to IDLE.
REQ-034 frame_done SHALL pulse for exactly one cycle, coincident with the first registered fval=0 cycle after TRAIL.
REQ-035 frame_count SHALL increment in that same cycle and wrap from 16'hFFFF to 0.
REQ-036 Counter widths SHALL be clog2 of the largest parameter they count, minimum 1 bit.
REQ-037 Any parameter set to 0 SHALL be treated as 1.

Reset
REQ-038 While reset=1, the FSM SHALL be IDLE and x, y and the phase counter SHALL be 0.
REQ-039 While reset=1, fval=0, lval=0, d=0, frame_done=0 and frame_count=0.
REQ-040 Reset asserted mid-frame SHALL drop fval and lval asynchronously, with no frame_done and no count increment.
REQ-041 After reset deasserts, the first frame SHALL start no earlier than one cycle after enable is sampled high.

Structure
REQ-042 Package camera_pattern_pkg SHALL hold the FSM state enum, the pattern code constants (PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_BAYER=3) and the 12-bit data width constant.
REQ-043 A single combinational sub-module, cam_pattern_pixel (inputs x, y, pattern; output 12-bit value), SHALL compute pixel values; all timing SHALL remain in camera_pattern_gen.

Verification (H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, FV_LEAD=1, FV_TRAIL=1, V_BLANK=3)
REQ-044 enable=1 held, pattern 0 -> frame period 21 cycles; fval high 18 cycles; three lval bursts of 4 separated by 2; d per line = 0,1,2,3.
REQ-045 Pattern 1 -> d is 0,0,0,0 / 1,1,1,1 / 2,2,2,2 per line; pattern_sel changed to 2 mid-frame -> no effect until the next frame.
REQ-046 enable dropped during line 1 -> frame completes, one frame_done pulse, frame_count=1, then IDLE with fval=0 indefinitely.
REQ-047 reset pulsed during HBLK -> fval, lval, d = 0 immediately; frame_count stays 0; the next frame restarts at y=0.
REQ-048 frame_count preloaded near 16'hFFFF by forcing, then two frames run -> value wraps to 0, one frame_done per frame.
REQ-049 Scoreboard check throughout: d=0 whenever lval=0, and lval=1 never occurs while fval=0.

Source files
------------

// File: rtl/camera_pattern_pkg.sv
// Shared types and constants for the camera test-pattern generator.
package camera_pattern_pkg;

  localparam int unsigned DATA_W = 12;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_BAYER = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LINE,
    HBLK,
    TRAIL,
    VBLK
  } state_e;

  // Zero-valued timing parameters behave as a single cycle.
  function automatic int unsigned at_least_1(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cam_pattern_pixel.sv
// Combinational pixel value for the selected test pattern at (x, y).
module cam_pattern_pixel
  import camera_pattern_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [1:0]        pattern,
  output logic [DATA_W-1:0] value
);

  always_comb begin
    value = '0;
    case (pattern)
      PAT_HRAMP: value = x;
      PAT_VRAMP: value = y;
      PAT_CHECK: value = (x[3] ^ y[3]) ? '1 : '0;
      PAT_BAYER: value = {x[1:0], y[1:0], 8'h00};
    endcase
  end

endmodule

// File: rtl/camera_pattern_gen.sv
// Camera-link style FVAL/LVAL/D test-pattern source with frame counting.
module camera_pattern_gen
  import camera_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4,
  parameter int unsigned V_BLANK  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic              fval,
  output logic              lval,
  output logic [DATA_W-1:0] d,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int unsigned HA = at_least_1(H_ACTIVE);
  localparam int unsigned VA = at_least_1(V_ACTIVE);
  localparam int unsigned HB = at_least_1(H_BLANK);
  localparam int unsigned FL = at_least_1(FV_LEAD);
  localparam int unsigned FT = at_least_1(FV_TRAIL);
  localparam int unsigned VB = at_least_1(V_BLANK);
  localparam int unsigned XW = cnt_w(HA);
  localparam int unsigned YW = cnt_w(VA);
  localparam int unsigned PW = cnt_w(max2(max2(HB, FL), max2(FT, VB)));

  state_e            state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [PW-1:0]     cnt_q;
  logic [1:0]        pat_q;
  logic              fval_q;
  logic              lval_q;
  logic [DATA_W-1:0] d_q;
  logic              frame_done_q;
  logic [15:0]       frame_count_q;
  logic [DATA_W-1:0] pix_c;
  logic              vblk_first_c;

  cam_pattern_pixel u_pixel (
    .x       (DATA_W'(x_q)),
    .y       (DATA_W'(y_q)),
    .pattern (pat_q),
    .value   (pix_c)
  );

  // First VBLK cycle is the cycle whose registered outputs show fval falling.
  assign vblk_first_c = (state_q == VBLK) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      pat_q         <= PAT_HRAMP;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      d_q           <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      fval_q       <= (state_q != IDLE) && (state_q != VBLK);
      lval_q       <= (state_q == LINE);
      d_q          <= (state_q == LINE) ? pix_c : '0;
      frame_done_q <= vblk_first_c;
      if (vblk_first_c) frame_count_q <= frame_count_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= LEAD;
            pat_q   <= pattern_sel;
            cnt_q   <= '0;
          end
        end
        LEAD: begin
          if (cnt_q == PW'(FL - 1)) begin
            state_q <= LINE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        LINE: begin
          if (x_q == XW'(HA - 1)) begin
            state_q <= (y_q == YW'(VA - 1)) ? TRAIL : HBLK;
            x_q     <= '0;
            cnt_q   <= '0;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        HBLK: begin
          if (cnt_q == PW'(HB - 1)) begin
            state_q <= LINE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= y_q + YW'(1);
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        TRAIL: begin
          if (cnt_q == PW'(FT - 1)) begin
            state_q <= VBLK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        VBLK: begin
          if (cnt_q == PW'(VB - 1)) begin
            cnt_q <= '0;
            if (enable) begin
              state_q <= LEAD;
              pat_q   <= pattern_sel;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fval        = fval_q;
  assign lval        = lval_q;
  assign d           = d_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Directed bench for camera_pattern_gen with a pixel scoreboard and timing monitor.
module tb_camera_pattern_gen;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        fval;
  logic        lval;
  logic [11:0] d;
  logic        frame_done;
  logic [15:0] frame_count;

  camera_pattern_gen #(
    .H_ACTIVE (4),
    .V_ACTIVE (3),
    .H_BLANK  (2),
    .FV_LEAD  (1),
    .FV_TRAIL (1),
    .V_BLANK  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .fval        (fval),
    .lval        (lval),
    .d           (d),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e_pix;

  int          cyc = 0;
  int          rise_cyc = 0;
  int          period_last = 0;
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          burst_cnt = 0;
  int          fval_run = 0;
  int          fval_len_last = 0;
  logic [31:0] lpat = '0;
  logic [31:0] lpat_last = '0;
  logic        fval_prev = 1'b0;
  logic        lval_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix_model(input int x, input int y, input int p);
    logic [11:0] xv;
    logic [11:0] yv;
    xv = 12'(x);
    yv = 12'(y);
    case (p)
      0:       return xv;
      1:       return yv;
      2:       return (xv[3] ^ yv[3]) ? 12'hFFF : 12'h000;
      default: return {xv[1:0], yv[1:0], 8'h00};
    endcase
  endfunction

  task automatic push_frame(input int p);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back(pix_model(x, y, p));
  endtask

  function automatic int cur(input int which);
    case (which)
      0:       return rise_cnt;
      1:       return done_cnt;
      2:       return burst_cnt;
      default: return int'(lval);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int target);
    int n = 0;
    while (cur(which) < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(cur(which) >= target), 1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Output monitor: invariants, pixel scoreboard and frame timing statistics.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("lval_outside_fval", 32'(lval & ~fval), 0);
      check("done_at_fval_fall", 32'(frame_done), 32'(fval_prev & ~fval));
      if (!lval) begin
        check("d_blank", 32'(d), 0);
      end else begin
        check("pix_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e_pix = exp_q.pop_front();
          check("pixel", 32'(d), 32'(e_pix));
        end
      end
      if (frame_done) done_cnt++;
    end
    if (fval && !fval_prev) begin
      rise_cnt++;
      period_last = cyc - rise_cyc;
      rise_cyc    = cyc;
    end
    if (fval) begin
      lpat = {lpat[30:0], lval};
      fval_run++;
    end else if (fval_prev) begin
      lpat_last     = lpat;
      fval_len_last = fval_run;
      lpat          = '0;
      fval_run      = 0;
    end
    if (!lval && lval_prev) burst_cnt++;
    fval_prev = fval;
    lval_prev = lval;
  end

  initial begin
    int r0;
    int d0;
    int b0;

    reset       = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;

    tick(1);
    check("rst_fval", 32'(fval), 0);
    check("rst_lval", 32'(lval), 0);
    check("rst_d", 32'(d), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    reset = 1'b0;
    tick(5);
    check("idle_hold_fval", 32'(fval), 0);

    // Enable dropped during line 1: frame completes, then idle.
    pattern_sel = 2'd3;
    push_frame(3);
    b0 = burst_cnt;
    d0 = done_cnt;
    enable = 1'b1;
    wait_for("wait_line0_end", 2, b0 + 1);
    wait_for("wait_line1_start", 3, 1);
    enable = 1'b0;
    wait_for("wait_done_stop", 1, d0 + 1);
    check("stop_frame_count", 32'(frame_count), 1);
    check("stop_queue_drained", 32'(exp_q.size()), 0);
    r0 = rise_cnt;
    tick(40);
    check("stop_no_restart", 32'(rise_cnt), 32'(r0));
    check("stop_fval_low", 32'(fval), 0);
    check("stop_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("stop_count_held", 32'(frame_count), 1);

    // Continuous frames; pattern changes only take effect at the next frame.
    pattern_sel = 2'd0;
    push_frame(0);
    push_frame(0);
    push_frame(1);
    push_frame(2);
    r0 = rise_cnt;
    d0 = done_cnt;
    enable = 1'b1;
    wait_for("wait_frame_b", 0, r0 + 2);
    pattern_sel = 2'd1;
    wait_for("wait_frame_c", 0, r0 + 3);
    pattern_sel = 2'd2;
    wait_for("wait_frame_d", 0, r0 + 4);
    enable = 1'b0;
    wait_for("wait_done_d", 1, d0 + 4);
    check("frame_period", 32'(period_last), 21);
    check("fval_high_len", 32'(fval_len_last), 18);
    check("lval_bursts", lpat_last, 32'(18'b011110011110011110));
    check("run_queue_drained", 32'(exp_q.size()), 0);
    check("run_frame_count", 32'(frame_count), 5);

    // Reset during horizontal blanking.
    pattern_sel = 2'd1;
    push_frame(1);
    b0 = burst_cnt;
    d0 = done_cnt;
    enable = 1'b1;
    wait_for("wait_hblk", 2, b0 + 1);
    reset = 1'b1;
    #1;
    check("arst_fval", 32'(fval), 0);
    check("arst_lval", 32'(lval), 0);
    check("arst_d", 32'(d), 0);
    check("arst_frame_count", 32'(frame_count), 0);
    exp_q.delete();
    tick(1);
    check("arst_no_done", 32'(frame_done), 0);
    reset = 1'b0;
    push_frame(1);
    r0 = rise_cnt;
    wait_for("wait_restart", 0, r0 + 1);
    enable = 1'b0;
    wait_for("wait_done_restart", 1, d0 + 1);
    check("restart_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("restart_frame_count", 32'(frame_count), 1);
    check("restart_queue_drained", 32'(exp_q.size()), 0);

    // Frame counter wrap.
    tick(10);
    force dut.frame_count_q = 16'hFFFE;
    tick(1);
    release dut.frame_count_q;
    tick(1);
    check("preload_count", 32'(frame_count), 32'h0000_FFFE);
    pattern_sel = 2'd0;
    push_frame(0);
    push_frame(0);
    r0 = rise_cnt;
    d0 = done_cnt;
    enable = 1'b1;
    wait_for("wait_wrap_done1", 1, d0 + 1);
    check("wrap_count_ffff", 32'(frame_count), 32'h0000_FFFF);
    wait_for("wait_wrap_rise2", 0, r0 + 2);
    enable = 1'b0;
    wait_for("wait_wrap_done2", 1, d0 + 2);
    check("wrap_count_zero", 32'(frame_count), 0);
    check("wrap_done_per_frame", 32'(done_cnt), 32'(d0 + 2));
    check("wrap_queue_drained", 32'(exp_q.size()), 0);
    tick(30);
    check("final_idle_fval", 32'(fval), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
